// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam logic PARITY_ODD       = 1'b0;
  localparam logic PARITY_EVEN      = 1'b1;
  localparam int   REF_CLK_PER_BAUD = 500;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // ptr itself is tried last, so the most recently served requester waits a full round.
  always_comb begin
    sel      = '0;
    index    = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!valid && req[cand_idx]) begin
        valid         = 1'b1;
        sel[cand_idx] = 1'b1;
        index         = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART Transmit block between NUM_REQ requesters: round-robin grant,
// launch handshake on tx_done, completion pulse, then an idle gap between frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ACK_TIMEOUT  = 2000,
  parameter int DONE_TIMEOUT = 8000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic                 ref_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_parity,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 transmit,
  output logic [7:0]           data_in,
  output logic                 parity,
  input  logic                 tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max3(ACK_TIMEOUT, DONE_TIMEOUT, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  arb_state_t         state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic               busy_reg;
  logic               err_reg;
  logic               transmit_reg;
  logic [7:0]         data_in_reg;
  logic               parity_reg;
  logic               tx_done_meta_reg;
  logic               tx_done_s_reg;
  logic               tx_done_prev_reg;

  logic [7:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] pick_sel;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_reg),
    .sel   (pick_sel),
    .index (pick_idx),
    .valid (pick_valid)
  );

  // Synchronizer flops idle high so a fresh LAUNCH never sees a stale low as an ack.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      ptr_reg          <= IDX_W'(NUM_REQ - 1);
      cnt_reg          <= '0;
      grant_reg        <= '0;
      done_reg         <= '0;
      busy_reg         <= 1'b0;
      err_reg          <= 1'b0;
      transmit_reg     <= 1'b0;
      data_in_reg      <= '0;
      parity_reg       <= 1'b0;
      tx_done_meta_reg <= 1'b1;
      tx_done_s_reg    <= 1'b1;
      tx_done_prev_reg <= 1'b1;
    end else begin
      grant_reg        <= '0;
      done_reg         <= '0;
      err_reg          <= 1'b0;
      tx_done_meta_reg <= tx_done;
      tx_done_s_reg    <= tx_done_meta_reg;
      tx_done_prev_reg <= tx_done_s_reg;

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg    <= pick_sel;
            data_in_reg  <= req_byte[pick_idx];
            parity_reg   <= req_parity[pick_idx];
            ptr_reg      <= pick_idx;
            transmit_reg <= 1'b1;
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= LAUNCH;
          end
        end

        LAUNCH: begin
          if (!tx_done_s_reg) begin
            transmit_reg <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= WAIT_DONE;
          end else if (cnt_reg == ACK_LAST) begin
            err_reg      <= 1'b1;
            transmit_reg <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (tx_done_s_reg && !tx_done_prev_reg) begin
            done_reg  <= NUM_REQ'(1) << ptr_reg;
            cnt_reg   <= '0;
            state_reg <= GAP;
          end else if (cnt_reg == DONE_LAST) begin
            err_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign err_timeout = err_reg;
  assign transmit    = transmit_reg;
  assign data_in     = data_in_reg;
  assign parity      = parity_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with shortened timeouts; tx_done is driven by hand.
module tb_uart_tx_arbiter;

  localparam int NR     = 4;
  localparam int ACK    = 20;
  localparam int DONE_T = 60;
  localparam int GAP    = 8;

  logic            ref_clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_parity = '0;
  logic            tx_done = 1'b1;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            busy;
  logic            err_timeout;
  logic            transmit;
  logic [7:0]      data_in;
  logic            parity;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .ACK_TIMEOUT  (ACK),
    .DONE_TIMEOUT (DONE_T),
    .GAP_CYCLES   (GAP)
  ) dut (
    .ref_clk     (ref_clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_parity  (req_parity),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .transmit    (transmit),
    .data_in     (data_in),
    .parity      (parity),
    .tx_done     (tx_done)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ref_clk);
  endtask

  task automatic wait_grant(input int k, input logic [7:0] d, input logic p, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (grant == '0 && lat < 100);
    check("grant", 32'(grant), 32'(1) << k);
    check("grant_data", 32'(data_in), 32'(d));
    check("grant_parity", 32'(parity), 32'(p));
    check("grant_busy", 32'(busy), 32'd1);
  endtask

  // Ack the launch, hold the frame in flight, then complete it and time the gap.
  task automatic complete(input int k, input logic [7:0] d, input logic p, input int toggle_lane);
    int n;
    check("transmit_on", 32'(transmit), 32'd1);
    tick();
    tick();
    check("transmit_held", 32'(transmit), 32'd1);
    tx_done = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (transmit && n < 20);
    check("ack_latency", 32'(n), 32'd3);
    repeat (6) begin
      tick();
      if (toggle_lane >= 0) req_parity[toggle_lane] = ~req_parity[toggle_lane];
    end
    check("data_stable", 32'(data_in), 32'(d));
    check("parity_stable", 32'(parity), 32'(p));
    check("no_early_done", 32'(done), 32'd0);
    tx_done = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (done == '0 && n < 20);
    check("done_onehot", 32'(done), 32'(1) << k);
    check("done_latency", 32'(n), 32'd3);
    tick();
    check("done_once", 32'(done), 32'd0);
    n = 1;
    while (busy && n < GAP + 20) begin
      tick();
      n++;
    end
    check("gap_len", 32'(n), 32'(GAP));
    $display("frame: requester %0d data %h parity %0b completed", k, d, p);
  endtask

  initial begin
    int lat;
    int n;

    // Reset state
    repeat (3) tick();
    check("reset_outs", 32'({grant, done, busy, err_timeout, transmit, data_in, parity}), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Round robin with all requests held: 0,1,2,3,0
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    req_parity = 4'b1010;
    req        = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      automatic int k = i % NR;
      automatic logic [7:0] d = 8'(8'h11 * (k + 1));
      wait_grant(k, d, req_parity[k], lat);
      if (i == 4) req = '0;
      complete(k, d, req_parity[k], -1);
    end

    // Single request, 1-cycle latency, B3 odd parity
    req_data   = {8'h44, 8'h33, 8'h22, 8'hB3};
    req_parity = 4'b0000;
    req        = 4'b0001;
    wait_grant(0, 8'hB3, 1'b0, lat);
    check("req_to_grant", 32'(lat), 32'd1);
    req = '0;
    complete(0, 8'hB3, 1'b0, -1);

    // Even parity latched and held while req_parity[2] toggles
    req_data   = {8'h44, 8'hB3, 8'h22, 8'h11};
    req_parity = 4'b0100;
    req        = 4'b0100;
    wait_grant(2, 8'hB3, 1'b1, lat);
    req = '0;
    complete(2, 8'hB3, 1'b1, 2);

    // ACK timeout: tx_done never falls
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    req_parity = 4'b0000;
    req        = 4'b0001;
    wait_grant(0, 8'h11, 1'b0, lat);
    req = '0;
    n = 0;
    do begin
      tick();
      n++;
      if (done != '0) check("ack_to_no_done", 32'(done), 32'd0);
    end while (!err_timeout && n < ACK + 10);
    check("ack_timeout_cycles", 32'(n), 32'(ACK));
    check("ack_to_transmit", 32'(transmit), 32'd0);
    tick();
    check("err_pulse_once", 32'(err_timeout), 32'd0);
    n = 1;
    while (busy && n < GAP + 20) begin
      tick();
      n++;
    end
    check("ack_to_gap", 32'(n), 32'(GAP));
    $display("frame: requester 0 ack timeout");

    // Next request still served
    req = 4'b0010;
    wait_grant(1, 8'h22, 1'b0, lat);
    req = '0;
    complete(1, 8'h22, 1'b0, -1);

    // DONE timeout: tx_done stays low after the ack
    req = 4'b1000;
    wait_grant(3, 8'h44, 1'b0, lat);
    req = '0;
    tx_done = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (transmit && n < 20);
    check("dto_ack_latency", 32'(n), 32'd3);
    n = 0;
    do begin
      tick();
      n++;
      if (done != '0) check("dto_no_done", 32'(done), 32'd0);
    end while (!err_timeout && n < DONE_T + 10);
    check("done_timeout_cycles", 32'(n), 32'(DONE_T));
    n = 0;
    while (busy && n < GAP + 20) begin
      tick();
      n++;
    end
    check("dto_gap", 32'(n), 32'(GAP));
    tx_done = 1'b1;
    repeat (3) tick();
    $display("frame: requester 3 done timeout");

    // Reset during WAIT_DONE; pointer restarts so requester 0 wins next
    req = 4'b0100;
    wait_grant(2, 8'h33, 1'b0, lat);
    req = '0;
    tx_done = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (transmit && n < 20);
    repeat (3) tick();
    reset   = 1'b1;
    tx_done = 1'b1;
    tick();
    check("midreset_outs", 32'({grant, done, busy, err_timeout, transmit, data_in, parity}), 32'd0);
    reset = 1'b0;
    req   = 4'b1111;
    wait_grant(0, 8'h11, 1'b0, lat);
    check("post_reset_latency", 32'(lat), 32'd1);
    req = '0;
    complete(0, 8'h11, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
